ram_queue_ctrl: RTL and testbench
=================================

# ram_queue_ctrl

Ready/valid FIFO controller that owns the pointers and occupancy state for the 16-entry x 46-bit register-file queue memory (`ram_16x46`) and drives its read and write ports directly. It sits between a producer and a consumer in the core's decoupled pipelines. Data is stored only in the memory; this block holds pointer, full/empty and count state. The block's outputs drive the memory's address, enable and write-data ports. The memory's read data returns to this block as `ram_R0_data`.

## Interface
- `DEPTH`, 16: number of entries; power of two; must match the memory.
- `WIDTH`, 46: payload width in bits.
- `ADDR_W`, log2(`DEPTH`) = 4: pointer width; derived, not overridden.

- `clock`  in  1  sole clock; the memory's `R0_clk`/`W0_clk` are tied to the same net.
- `reset`  in  1  asynchronous, active-high reset.
- `enq_valid`  in  1  producer has data.
- `enq_ready`  out  1  queue can accept.
- `enq_bits`  in  WIDTH  producer payload.
- `deq_valid`  out  1  queue has data.
- `deq_ready`  in  1  consumer accepts.
- `deq_bits`  out  WIDTH  head payload.
- `flush`  in  1  synchronous discard of all entries.
- `count`  out  ADDR_W+1  occupancy, 0..DEPTH.
- `ram_W0_addr`  out  ADDR_W  memory write address.
- `ram_W0_en`  out  1  memory write enable.
- `ram_W0_data`  out  WIDTH  memory write data.
- `ram_R0_addr`  out  ADDR_W  memory read address.
- `ram_R0_en`  out  1  memory read enable.
- `ram_R0_data`  in  WIDTH  memory read data (combinational from `ram_R0_addr`).

## Operation
- **State**
  - `enq_ptr` and `deq_ptr` are ADDR_W-bit registers.
  - `maybe_full` is a 1-bit register.
  - `empty` = (`enq_ptr` == `deq_ptr`) && !`maybe_full`.
  - `full` = (`enq_ptr` == `deq_ptr`) && `maybe_full`.
- **Handshake**
  - `enq_ready` = !`full`.
  - `deq_valid` = !`empty`.
  - `do_enq` = `enq_valid` && `enq_ready`.
  - `do_deq` = `deq_valid` && `deq_ready`.
- **Memory drive**
  - `ram_W0_en` = `do_enq` && !`flush`.
  - `ram_W0_addr` = `enq_ptr`.
  - `ram_W0_data` = `enq_bits`.
  - `ram_R0_en` = 1.
  - `ram_R0_addr` = `deq_ptr`.
  - `deq_bits` = `ram_R0_data`.
- **Pointer update**
  - `enq_ptr` increments on `do_enq`.
  - `deq_ptr` increments on `do_deq`.
  - Both wrap modulo DEPTH (15 -> 0) by natural overflow.
  - If `do_enq` != `do_deq`, `maybe_full` <= `do_enq`; otherwise it holds.
- **Count**
  - `count` = `maybe_full` && ptrs equal ? DEPTH : (`enq_ptr` - `deq_ptr`) mod DEPTH.
  - Computed combinationally from state; never exceeds DEPTH.
- **Flush**
  - Next cycle: `enq_ptr` = `deq_ptr` = 0 and `maybe_full` = 0.
  - Flush has priority: same-cycle enq and deq handshakes are discarded and no memory write is issued.
  - Memory contents are not cleared.
- **Boundary conditions**
  - Full with both `enq_valid` and `deq_ready` high: only the dequeue occurs, because `enq_ready` is 0. Next cycle `count` = 15 and `enq_ready` = 1.
  - Empty with `deq_ready` high: no transfer and no pointer change.
  - Simultaneous enq and deq when partially full: `count` is unchanged and both pointers advance.

## Timing
- **Reset values:**
  - Internal state: `enq_ptr` = 0, `deq_ptr` = 0, `maybe_full` = 0.
  - Outputs: `enq_ready` = 1, `deq_valid` = 0, `count` = 0, `ram_W0_en` = 0, `ram_W0_addr` = 0, `ram_R0_addr` = 0.
- **Reset mid-operation:** reset asynchronously clears state and outputs immediately. Memory contents are left intact but unreachable.
- **Latency:**
  - An entry written at edge N is visible on `deq_bits` with `deq_valid` = 1 after edge N.
  - Minimum enq-to-deq latency is 1 cycle.
- **Throughput:** one enqueue and one dequeue per cycle, sustained.
- **Combinational paths:**
  - `enq_ready` and `deq_valid` depend only on registered state.
  - `deq_bits` depends combinationally on `ram_R0_data`.

## Configuration
- Macro: `RAM_QUEUE_FLOW_EN`.
- **When defined**, flow-through applies while `empty`:
  - `deq_valid` = `enq_valid` and `deq_bits` = `enq_bits`.
  - If `deq_ready` is also high, the item bypasses storage: no memory write, and pointers and `maybe_full` are unchanged. Latency is 0 cycles.
  - If `deq_ready` is low, the item is enqueued normally.
- **When undefined**, empty always means `deq_valid` = 0 and the minimum latency is 1 cycle.

## Test plan
- **Reset/idle:** assert `reset` asynchronously mid-cycle -> immediately `enq_ready` = 1, `deq_valid` = 0, `count` = 0, `ram_W0_en` = 0.
- **Fill:** 16 back-to-back enqueues of 46'h1..46'h10 with `deq_ready` = 0 -> `count` reaches 16, `enq_ready` = 0. A 17th `enq_valid` causes no write.
- **Drain/wrap:** from full, dequeue 16 -> order 46'h1..46'h10, `count` returns to 0. Then 20 streaming enq+deq cycles -> pointers wrap 15->0 with no loss and `count` stays 1.
- **Full with simultaneous valid/ready:** both high -> dequeue only; next cycle `count` = 15 and `enq_ready` = 1.
- **Flush:** with 5 entries, assert `flush` together with `enq_valid` and `deq_ready` -> no write, next cycle `count` = 0 and `deq_valid` = 0.
- **Flow (`RAM_QUEUE_FLOW_EN`):**
  - Empty queue, `enq_valid` = 1 with 46'h2A5A5, `deq_ready` = 1 -> same cycle `deq_bits` = 46'h2A5A5, no `ram_W0_en`, `count` stays 0.
  - Without the macro -> `deq_valid` = 0 that cycle and 1 the next.

Source files
------------

// File: rtl/ram_queue_ctrl.sv
// Pointer/occupancy controller for a DEPTH x WIDTH register-file queue; drives the RAM ports directly.
// Optional flow-through of an empty queue when RAM_QUEUE_FLOW_EN is defined.
module ram_queue_ctrl #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 46,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_bits,
  input  logic              flush,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_W0_addr,
  output logic              ram_W0_en,
  output logic [WIDTH-1:0]  ram_W0_data,
  output logic [ADDR_W-1:0] ram_R0_addr,
  output logic              ram_R0_en,
  input  logic [WIDTH-1:0]  ram_R0_data
);

  logic [ADDR_W-1:0] enq_ptr_q, enq_ptr_d;
  logic [ADDR_W-1:0] deq_ptr_q, deq_ptr_d;
  logic              maybe_full_q, maybe_full_d;
  logic              ptr_eq, empty, full, do_enq, do_deq;

  assign ptr_eq = (enq_ptr_q == deq_ptr_q);
  assign empty  = ptr_eq && !maybe_full_q;
  assign full   = ptr_eq && maybe_full_q;

  assign enq_ready = !full;
  assign do_deq    = !empty && deq_ready;

`ifdef RAM_QUEUE_FLOW_EN
  // An empty queue hands the producer's item straight to a ready consumer without storing it.
  logic bypass;
  assign bypass    = empty && enq_valid && deq_ready;
  assign do_enq    = enq_valid && enq_ready && !bypass;
  assign deq_valid = !empty || enq_valid;
  assign deq_bits  = empty ? enq_bits : ram_R0_data;
`else
  assign do_enq    = enq_valid && enq_ready;
  assign deq_valid = !empty;
  assign deq_bits  = ram_R0_data;
`endif

  assign ram_W0_en   = do_enq && !flush;
  assign ram_W0_addr = enq_ptr_q;
  assign ram_W0_data = enq_bits;
  assign ram_R0_en   = 1'b1;
  assign ram_R0_addr = deq_ptr_q;

  assign count = full ? (ADDR_W+1)'(DEPTH) : {1'b0, enq_ptr_q - deq_ptr_q};

  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (flush) begin
      enq_ptr_d    = '0;
      deq_ptr_d    = '0;
      maybe_full_d = 1'b0;
    end else begin
      if (do_enq) enq_ptr_d = ADDR_W'(enq_ptr_q + 1'b1);
      if (do_deq) deq_ptr_d = ADDR_W'(deq_ptr_q + 1'b1);
      if (do_enq != do_deq) maybe_full_d = do_enq;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

endmodule

// File: tb/tb_ram_queue_ctrl.sv
// Directed bench for ram_queue_ctrl: queue-based model checked every cycle plus literal spot checks.
module tb_ram_queue_ctrl;
  localparam int W = 46;

  logic          clock = 1'b0;
  logic          reset;
  logic          enq_valid, enq_ready, deq_valid, deq_ready, flush;
  logic [W-1:0]  enq_bits, deq_bits, ram_W0_data, ram_R0_data;
  logic [4:0]    count;
  logic [3:0]    ram_W0_addr, ram_R0_addr;
  logic          ram_W0_en, ram_R0_en;

  always #5 clock = ~clock;

  ram_queue_ctrl dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .flush(flush), .count(count),
    .ram_W0_addr(ram_W0_addr), .ram_W0_en(ram_W0_en), .ram_W0_data(ram_W0_data),
    .ram_R0_addr(ram_R0_addr), .ram_R0_en(ram_R0_en), .ram_R0_data(ram_R0_data)
  );

  // Behavioural stand-in for ram_16x46
  logic [W-1:0] mem [16];
  always @(posedge clock) if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
  assign ram_R0_data = mem[ram_R0_addr];

`ifdef RAM_QUEUE_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  logic [W-1:0] q[$];
  logic [W-1:0] got[$];
  int wr_idx, rd_idx;
  int pass_cnt = 0, tot_cnt = 0;
  logic         obs_dv, obs_w0en;
  logic [W-1:0] obs_bits;
  logic [4:0]   obs_count;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    wr_idx = 0;
    rd_idx = 0;
  endtask

  // One clock: drive, compare against the queue model, then advance the model at the edge.
  task automatic cycle(input logic ev, input logic [W-1:0] eb, input logic dr, input logic fl);
    int  sz;
    bit  byp, e_rdy, e_dv, m_enq, m_deq;
    @(negedge clock);
    enq_valid = ev; enq_bits = eb; deq_ready = dr; flush = fl;
    #1;
    sz    = q.size();
    byp   = FLOW && sz == 0 && ev && dr;
    e_rdy = sz < 16;
    e_dv  = sz > 0 || (FLOW && ev);
    m_enq = ev && e_rdy && !byp;
    m_deq = sz > 0 && dr;
    chk("enq_ready", enq_ready, e_rdy);
    chk("deq_valid", deq_valid, e_dv);
    chk("count", count, sz);
    chk("w0_en", ram_W0_en, m_enq && !fl);
    chk("r0_en", ram_R0_en, 1);
    chk("r0_addr", ram_R0_addr, rd_idx);
    if (m_enq && !fl) begin
      chk("w0_addr", ram_W0_addr, wr_idx);
      chk("w0_data", ram_W0_data, eb);
    end
    if (e_dv) chk("deq_bits", deq_bits, (sz > 0) ? q[0] : eb);
    obs_dv = deq_valid; obs_bits = deq_bits; obs_w0en = ram_W0_en; obs_count = count;
    @(posedge clock);
    if (fl) model_reset();
    else begin
      if (m_deq) begin got.push_back(q.pop_front()); rd_idx = (rd_idx + 1) % 16; end
      if (m_enq) begin q.push_back(eb); wr_idx = (wr_idx + 1) % 16; end
    end
  endtask

  task automatic idle_look();
    @(negedge clock);
    enq_valid = 0; enq_bits = '0; deq_ready = 0; flush = 0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1; enq_valid = 0; enq_bits = '0; deq_ready = 0; flush = 0;
    model_reset();
    #12;
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_w0_en", ram_W0_en, 0);
    chk("rst_w0_addr", ram_W0_addr, 0);
    chk("rst_r0_addr", ram_R0_addr, 0);
    @(negedge clock); reset = 0;

    // Empty with deq_ready: nothing moves
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Fill 1..16
    for (int i = 1; i <= 16; i++) cycle(1, W'(i), 0, 0);
    idle_look();
    chk("fill_count", count, 16);
    chk("fill_enq_ready", enq_ready, 0);
    cycle(1, W'(17), 0, 0);
    chk("full_no_write", obs_w0en, 0);

    // Drain in order
    got.delete();
    for (int i = 0; i < 16; i++) cycle(0, '0, 1, 0);
    for (int i = 0; i < 16; i++) chk("drain_order", (i < got.size()) ? got[i] : 'x, W'(i + 1));
    idle_look();
    chk("drain_count", count, 0);

    // Streaming enq+deq across the pointer wrap
    for (int i = 0; i < 20; i++) cycle(1, W'(100 + i), 1, 0);
    idle_look();
    chk("stream_count", count, FLOW ? 0 : 1);
    cycle(0, '0, 1, 0);

    // Full with both valid and ready: dequeue only
    for (int i = 0; i < 16; i++) cycle(1, W'(200 + i), 0, 0);
    cycle(1, W'(999), 1, 0);
    chk("fullsim_no_write", obs_w0en, 0);
    idle_look();
    chk("fullsim_count", count, 15);
    chk("fullsim_enq_ready", enq_ready, 1);

    // Flush with 5 entries and live handshakes
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, W'(300 + i), 0, 0);
    cycle(1, W'('h77), 1, 1);
    chk("flush_no_write", obs_w0en, 0);
    idle_look();
    chk("flush_count", count, 0);
    chk("flush_deq_valid", deq_valid, 0);

    // Flow-through (or 1-cycle latency without it)
    cycle(1, W'('h2A5A5), 1, 0);
    chk("flow_dv", obs_dv, FLOW);
    chk("flow_count", obs_count, 0);
    if (FLOW) begin
      chk("flow_bits", obs_bits, W'('h2A5A5));
      chk("flow_no_write", obs_w0en, 0);
    end else begin
      chk("lat_write", obs_w0en, 1);
    end
    cycle(0, '0, 1, 0);
    chk("lat_next_dv", obs_dv, !FLOW);
    if (!FLOW) chk("lat_next_bits", obs_bits, W'('h2A5A5));

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1, W'(400 + i), 0, 0);
    @(negedge clock); enq_valid = 0; deq_ready = 0;
    @(posedge clock); #2;
    reset = 1; #1;
    chk("arst_enq_ready", enq_ready, 1);
    chk("arst_deq_valid", deq_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_w0_en", ram_W0_en, 0);
    model_reset();
    @(negedge clock); reset = 0;
    for (int i = 0; i < 4; i++) cycle(1, W'(500 + i), i[0], 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
